// File: rtl/hilo_md_unit_pkg.sv
// Shared constants and types for the HI/LO multiply/divide unit and the decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hilo_md_unit_pkg;

    localparam logic [3:0] HLU_NONE = 4'b0000;
    localparam logic [3:0] HLU_MULT = 4'b0001;
    localparam logic [3:0] HLU_DIV  = 4'b0010;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_divider.sv
// Signed/unsigned truncating divide with defined divide-by-zero and MIN_INT/-1 results.
// Latency: combinational.
// Backpressure: none; the caller latches the result when it accepts the op.
module md_divider #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_unsigned,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;

    // Divide magnitudes and restore signs afterwards. MIN_INT has magnitude
    // 2^(WIDTH-1) as an unsigned value, so MIN_INT / -1 yields MIN_INT, rem 0.
    always_comb begin
        neg_a    = ~is_unsigned & dividend[WIDTH-1];
        neg_b    = ~is_unsigned & divisor[WIDTH-1];
        mag_a    = neg_a ? (~dividend + 1'b1) : dividend;
        mag_b    = neg_b ? (~divisor + 1'b1) : divisor;
        div_zero = (divisor == '0);
        q_mag    = '0;
        r_mag    = '0;
        if (!div_zero) begin
            q_mag = mag_a / mag_b;
            r_mag = mag_a % mag_b;
        end
        quotient  = (neg_a ^ neg_b) ? (~q_mag + 1'b1) : q_mag;
        remainder = neg_a ? (~r_mag + 1'b1) : r_mag;
    end

endmodule

// File: rtl/hilo_md_unit.sv
// HI/LO register pair with multi-cycle mult/div, mthi/mtlo writes and mfhi/mflo read.
// Latency: MULT_CYCLES / DIV_CYCLES busy cycles; mthi/mtlo visible next cycle.
// Backpressure: busy flags the hazard unit to stall; start/write_en while busy are ignored.
module hilo_md_unit
    import hilo_md_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             write_en,
    input  logic             write_hi,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam int MAX_CYC = max_int(MULT_CYCLES, DIV_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t          state;
    md_state_t          state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   sh_hi;
    logic [WIDTH-1:0]   sh_lo;
    logic               sh_keep;
    logic               is_md_op;
    logic               accept;
    logic               commit;
    logic               wr_fire;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   div_r;
    logic               div_zero;

    md_divider #(.WIDTH(WIDTH)) u_div (
        .dividend    (src_a),
        .divisor     (src_b),
        .is_unsigned (is_unsigned),
        .quotient    (div_q),
        .remainder   (div_r),
        .div_zero    (div_zero)
    );

    // Sign/zero-extend to 2*WIDTH; the low 2*WIDTH bits of that product are exact.
    always_comb begin
        ext_a = {{WIDTH{~is_unsigned & src_a[WIDTH-1]}}, src_a};
        ext_b = {{WIDTH{~is_unsigned & src_b[WIDTH-1]}}, src_b};
        prod  = ext_a * ext_b;
    end

    always_comb begin
        is_md_op  = (op == HLU_MULT) || (op == HLU_DIV);
        accept    = 1'b0;
        commit    = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                accept = start & ~cancel & is_md_op;
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                commit = (cnt == '0);
                if (commit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        wr_fire = write_en & ~cancel & ~busy & ~start;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            sh_hi   <= '0;
            sh_lo   <= '0;
            sh_keep <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (op == HLU_MULT) begin
                    cnt     <= MULT_LOAD;
                    sh_hi   <= prod[2*WIDTH-1:WIDTH];
                    sh_lo   <= prod[WIDTH-1:0];
                    sh_keep <= 1'b0;
                end else begin
                    cnt     <= DIV_LOAD;
                    sh_hi   <= div_r;
                    sh_lo   <= div_q;
                    sh_keep <= div_zero;
                end
            end else if (state == RUN && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                if (!sh_keep) begin
                    hi <= sh_hi;
                    lo <= sh_lo;
                end
            end else if (wr_fire) begin
                if (write_hi) hi <= src_a;
                else          lo <= src_a;
            end
        end
    end

    assign busy  = (state == RUN);
    assign rdata = write_hi ? hi : lo;

endmodule
